// File: rtl/baud_rate_ctrl.sv
// baud_rate_ctrl
//   Programmable baud-tick generator with a req/ack reconfiguration handshake.
//   tick_16x is a one-cycle enable for the RX oversampler and tick_1x (every
//   16th tick_16x) is the TX bit-timer enable. A new divisor is captured when
//   the request is accepted and applied only once TX and RX are both idle.
//
//   Optional feature: define BAUD_RATE_CTRL_FRAC_EN to enable the fractional
//   divider (period alternates between cur_div and cur_div+1 so that the
//   average is cur_div + cur_frac/16). Without it cfg_frac is ignored and
//   cur_frac reads 0.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   en                  tick generation enable (0 holds the divider at zero)
//   cfg_req             reconfiguration request, held until cfg_ack
//   cfg_div, cfg_frac   requested integer / fractional (1/16) divisor
//   cfg_ack, cfg_err    one-cycle completion, error flag for rejected divisor
//   tx_busy, rx_busy    frame-in-progress indicators from TX / RX
//   tick_16x, tick_1x   one-cycle oversample / bit ticks
//   cur_div, cur_frac   active divisor
module baud_rate_ctrl #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [3:0]       cfg_frac,
    output logic             cfg_ack,
    output logic             cfg_err,
    input  logic             tx_busy,
    input  logic             rx_busy,
    output logic             tick_16x,
    output logic             tick_1x,
    output logic [DIV_W-1:0] cur_div,
    output logic [3:0]       cur_frac
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_DONE_OK,
        ST_DONE_ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [DIV_W-1:0] cnt;
    logic [3:0]       sub;
    logic [DIV_W-1:0] pend_div;
    logic             long_per;   // current period is cur_div+1 (fractional carry)
    logic [DIV_W:0]   period_m1;
    logic             cnt_end;
    logic             load;
    logic             hold;
    logic             accept;

    assign accept = (state == ST_RUN) && cfg_req;
    // New config is applied on the edge leaving PEND, so cur_div changes in
    // the DONE cycle.
    assign load   = (state == ST_PEND) && !tx_busy && !rx_busy;
    // The DONE(ok) cycle behaves like en=0: counter parked at 0, no tick.
    assign hold   = !en || (state == ST_DONE_OK);

    // One extra bit so that cur_div = 2^DIV_W-1 plus the fractional carry
    // still compares correctly against the DIV_W-bit counter.
    assign period_m1 = {1'b0, cur_div} + {{DIV_W{1'b0}}, long_per}
                     - {{DIV_W{1'b0}}, 1'b1};
    assign cnt_end   = ({1'b0, cnt} == period_m1);
    assign tick_16x  = !hold && cnt_end;
    assign tick_1x   = tick_16x && (sub == 4'hF);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ack   = 1'b0;
        cfg_err   = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (cfg_req) begin
                    state_nxt = (cfg_div < DIV_W'(2)) ? ST_DONE_ERR : ST_PEND;
                end
            end
            ST_PEND: begin
                if (!tx_busy && !rx_busy) begin
                    state_nxt = ST_DONE_OK;
                end
            end
            ST_DONE_OK: begin
                cfg_ack   = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_DONE_ERR: begin
                cfg_ack   = 1'b1;
                cfg_err   = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // ------------------------------------------------------ configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_div <= '0;
            cur_div  <= DIV_W'(DEF_DIV);
        end else begin
            if (accept) begin
                pend_div <= cfg_div;
            end
            if (load) begin
                cur_div <= pend_div;
            end
        end
    end

`ifdef BAUD_RATE_CTRL_FRAC_EN
    logic [3:0] pend_frac;
    logic [3:0] acc;
    logic [4:0] acc_sum;
    logic       long_r;

    assign acc_sum  = {1'b0, acc} + {1'b0, cur_frac};
    assign long_per = long_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_frac <= '0;
            cur_frac  <= '0;
            acc       <= '0;
            long_r    <= 1'b0;
        end else begin
            if (accept) begin
                pend_frac <= cfg_frac;
            end
            if (load) begin
                cur_frac <= pend_frac;
                acc      <= '0;
                long_r   <= 1'b0;
            end else if (tick_16x) begin
                // Carry out of the 1/16 accumulator stretches the next period.
                acc    <= acc_sum[3:0];
                long_r <= acc_sum[4];
            end
        end
    end
`else
    logic unused_cfg_frac;

    assign unused_cfg_frac = ^cfg_frac;
    assign cur_frac        = '0;
    assign long_per        = 1'b0;
`endif

    // ------------------------------------------------------------ divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sub <= '0;
        end else if (load || hold) begin
            cnt <= '0;
            sub <= '0;
        end else if (cnt_end) begin
            cnt <= '0;
            sub <= sub + 4'd1;
        end else begin
            cnt <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/baud_rate_ctrl.md
# baud_rate_ctrl

Programmable baud-tick generator and reconfiguration controller for the UART. It replaces the fixed divide-by-16 clock with single-cycle enable ticks: `tick_16x` drives the RX oversampler and `tick_1x` drives the TX bit timer. A new divisor is accepted through a req/ack handshake and takes effect only once both TX and RX report idle, so no character in flight is corrupted.

## Interface
- `DIV_W`, 16, width of the divisor.
- `DEF_DIV`, 27, reset divisor in clk cycles per `tick_16x` (50 MHz / 115200 / 16).
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: tick generation enable.
- `cfg_req` input 1: reconfiguration request, held until `cfg_ack`.
- `cfg_div` input DIV_W: requested divisor, captured on accept.
- `cfg_frac` input 4: requested fractional divisor in 1/16 units, captured on accept.
- `cfg_ack` output 1: one-cycle request completion.
- `cfg_err` output 1: one-cycle pulse, coincident with `cfg_ack`, when the request was rejected.
- `tx_busy` input 1: TX frame in progress.
- `rx_busy` input 1: RX frame in progress.
- `tick_16x` output 1: one-cycle oversample tick.
- `tick_1x` output 1: one-cycle bit tick, every 16th `tick_16x`.
- `cur_div` output DIV_W: active divisor.
- `cur_frac` output 4: active fractional divisor.

## Operation
- Reset values:
  - state RUN.
  - `cur_div`=DEF_DIV, `cur_frac`=0.
  - Internal `cnt`=0, `sub`=0, `acc`=0.
  - All 1-bit outputs 0.
- Divider:
  - `cnt` counts 0..period-1.
  - `tick_16x` is high in the cycle where `cnt`==period-1; `cnt` then wraps to 0.
  - `sub` (4-bit) increments on each `tick_16x`.
  - `tick_1x` is high in the same cycle as a `tick_16x` with `sub`==15; `sub` wraps to 0.
  - Base period is `cur_div`.
- `en`=0: `cnt` and `sub` are held at 0 and no ticks are produced. The handshake still operates.
- States:
  - RUN: when `cfg_req`=1, capture `cfg_div`/`cfg_frac`. If captured div<2, go to DONE(err). Otherwise go to PEND.
  - PEND: ticks continue at the old rate. When `tx_busy`=0 and `rx_busy`=0, go to DONE(ok). `cfg_req` is ignored in this state.
  - DONE: lasts one cycle; `cfg_ack`=1, and `cfg_err`=1 for the err case. Always returns to RUN. `cfg_req` is ignored in this state.
- Entering DONE(ok):
  - Load `cur_div`/`cur_frac`.
  - Clear `cnt`, `sub`, `acc`.
  - No tick in the DONE cycle.
  - `cnt` resumes from 0 in the following cycle.
- DONE(err): divider and active config are untouched.
- Requester: deassert `cfg_req` in the cycle after `cfg_ack`. A request still high then starts a new transaction.
- Arithmetic:
  - `cnt` is DIV_W bits wide; period is at most 2^DIV_W-1 without the fractional feature.
  - With the fractional feature, period div+1 must fit in DIV_W+1 bits.

## Timing
- Accept in cycle N:
  - Valid request with TX/RX idle: PEND at N+1, DONE at N+2. `cur_div` shows the new value from N+2.
  - First new `tick_16x` at N+2+period.
  - Error path: `cfg_ack`/`cfg_err` at N+1.
- Busy during PEND: ack follows 1 cycle after the first cycle in which both busy inputs are sampled low.
- `en` rising in cycle E: first `tick_16x` at E+period-1.
- `en` dropping: no tick in the same cycle, even if `cnt`==period-1.
- Reset asserted mid-operation: immediate return to reset values. A pending request is dropped with no ack.

## Configuration
- Macro `BAUD_RATE_CTRL_FRAC_EN`.
- Defined:
  - At each `tick_16x`, `acc`<=`acc`+`cur_frac` (4-bit).
  - If that add carries out, the next period is `cur_div`+1 cycles, otherwise `cur_div`.
  - Average period is `cur_div`+`cur_frac`/16.
- Undefined:
  - `cfg_frac` is ignored and `cur_frac` is tied to 0.
  - `acc` is absent; period is always `cur_div`.

## Test plan
- Reset, then `en`=1 with DEF_DIV=27 -> `tick_16x` every 27 cycles, `tick_1x` every 432 cycles, `cur_div`=27.
- `cfg_req` with `cfg_div`=10 while both busy signals are low, accepted in cycle N -> `cfg_ack` at N+2, `cfg_err`=0, `cur_div`=10, next `tick_16x` at N+12, then every 10 cycles.
- `tx_busy`=1 during the request -> no ack and 27-cycle ticks continue. Drop `tx_busy` at cycle M (`rx_busy`=0) -> `cfg_ack` at M+1.
- `cfg_div`=1 accepted at N -> `cfg_ack`=`cfg_err`=1 at N+1, `cur_div` stays 27, tick spacing unbroken.
- Fractional build, `cfg_div`=27 with `cfg_frac`=2 -> 16 consecutive `tick_16x` periods total 434 cycles, exactly 2 of them 28 cycles long. Non-fractional build -> 432 cycles, `cur_frac`=0.
- `rst_n` pulsed low while in PEND -> no `cfg_ack`, `cur_div`=27, ticks restart 27 cycles after `en` is sampled high.
